// File: rtl/axil_fifo_client.sv
// AXI4-Lite slave endpoint that turns AXI-Lite reads/writes into a simple
// valid/ready request stream and routes one response word per request back
// onto the B or R channel, in request order.

// Small synchronous FIFO used for the AW, W, AR and tag buffers.
module axil_fifo_client_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(els_p - 1)) return '0;
    else                           return p + 1'b1;
  endfunction

  // Ready/valid come from the registered count only, so valid never feeds ready.
  always_comb begin
    ready_o  = (cnt_q != cnt_w_lp'(els_p));
    v_o      = (cnt_q != '0);
    data_o   = mem_q[rd_ptr_q];
    enq      = v_i & ready_o;
    deq      = yumi_i & v_o;
    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  // Pointer and occupancy state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module axil_fifo_client #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int fifo_els_p        = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  // request stream
  output logic [axil_data_width_p-1:0]   data_o,
  output logic [axil_addr_width_p-1:0]   addr_o,
  output logic                           v_o,
  output logic                           w_o,
  output logic [axil_data_width_p/8-1:0] wmask_o,
  input  logic                           ready_and_i,
  // response stream
  input  logic [axil_data_width_p-1:0]   data_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  // AXI-Lite write address
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  // AXI-Lite write data
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  // AXI-Lite write response
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  // AXI-Lite read address
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  // AXI-Lite read data
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i
);
  localparam int mask_w_lp = axil_data_width_p / 8;

  logic                         aw_ready, aw_v, aw_yumi;
  logic [axil_addr_width_p-1:0] aw_addr;
  logic                         w_ready, w_v, w_yumi;
  logic [axil_data_width_p-1:0] w_data;
  logic [mask_w_lp-1:0]         w_mask;
  logic                         ar_ready, ar_v, ar_yumi;
  logic [axil_addr_width_p-1:0] ar_addr;
  logic                         tag_ready, tag_v, tag_head, tag_yumi;
  logic                         wr_cand, rd_cand, sel_write, req_v, req_hs, resp_open;
  logic                         lock_q, lock_d, lock_w_q, lock_w_d;
  logic                         unused_prot;

  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

  axil_fifo_client_fifo #(.width_p(axil_addr_width_p), .els_p(fifo_els_p)) aw_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(s_axil_awaddr_i), .v_i(s_axil_awvalid_i), .ready_o(aw_ready),
    .data_o(aw_addr), .v_o(aw_v), .yumi_i(aw_yumi)
  );

  axil_fifo_client_fifo #(.width_p(axil_data_width_p + mask_w_lp), .els_p(fifo_els_p)) w_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i({s_axil_wstrb_i, s_axil_wdata_i}), .v_i(s_axil_wvalid_i), .ready_o(w_ready),
    .data_o({w_mask, w_data}), .v_o(w_v), .yumi_i(w_yumi)
  );

  axil_fifo_client_fifo #(.width_p(axil_addr_width_p), .els_p(fifo_els_p)) ar_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(s_axil_araddr_i), .v_i(s_axil_arvalid_i), .ready_o(ar_ready),
    .data_o(ar_addr), .v_o(ar_v), .yumi_i(ar_yumi)
  );

  // Outstanding-request queue: one tag per issued request, 1 = write.
  axil_fifo_client_fifo #(.width_p(1), .els_p(fifo_els_p)) tag_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(sel_write), .v_i(req_hs), .ready_o(tag_ready),
    .data_o(tag_head), .v_o(tag_v), .yumi_i(tag_yumi)
  );

  // Request selection: writes win, but a stalled request keeps its selection
  // so a write arriving behind a stalled read cannot change the presented request.
  always_comb begin
    wr_cand   = aw_v & w_v;
    rd_cand   = ar_v;
    sel_write = lock_q ? lock_w_q : wr_cand;
    req_v     = (wr_cand | rd_cand) & tag_ready & ~reset_i;
    req_hs    = req_v & ready_and_i;
    aw_yumi   = req_hs & sel_write;
    w_yumi    = req_hs & sel_write;
    ar_yumi   = req_hs & ~sel_write;
    lock_d    = req_v & ~ready_and_i;
    lock_w_d  = sel_write;
    v_o       = req_v;
    w_o       = sel_write;
    addr_o    = sel_write ? aw_addr : ar_addr;
    data_o    = sel_write ? w_data  : '0;
    wmask_o   = sel_write ? w_mask  : '0;
  end

  // Response routing by the head tag; purely combinational.
  always_comb begin
    resp_open        = tag_v & ~reset_i;
    ready_and_o      = resp_open & (tag_head ? s_axil_bready_i : s_axil_rready_i);
    s_axil_bvalid_o  = resp_open & tag_head & v_i;
    s_axil_rvalid_o  = resp_open & ~tag_head & v_i;
    s_axil_rdata_o   = data_i;
    s_axil_bresp_o   = 2'b00;
    s_axil_rresp_o   = 2'b00;
    tag_yumi         = v_i & ready_and_o;
    s_axil_awready_o = aw_ready & ~reset_i;
    s_axil_wready_o  = w_ready & ~reset_i;
    s_axil_arready_o = ar_ready & ~reset_i;
  end

  // Selection lock register for a stalled request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q   <= 1'b0;
      lock_w_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      lock_w_q <= lock_w_d;
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: responses need an outstanding request; depth must be usable.
  always_ff @(posedge clk_i) begin
    assert (fifo_els_p >= 1) else $error("axil_fifo_client: fifo_els_p must be >= 1");
    if (!reset_i) begin
      assert (!(v_i && !tag_v)) else $error("axil_fifo_client: response with no outstanding request");
    end
  end
`endif
endmodule

// File: tb/tb_axil_fifo_client.sv
// Self-checking bench for axil_fifo_client: directed scenarios plus a random
// phase, all compared against a queue-based transaction model.
module tb_axil_fifo_client;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_o, addr_o, data_i;
  logic        v_o, w_o, ready_and_i, v_i, ready_and_o;
  logic [3:0]  wmask_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, arvalid, arready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, rvalid, rready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  axil_fifo_client #(.axil_data_width_p(32), .axil_addr_width_p(32), .fifo_els_p(DEPTH)) dut (
    .clk_i(clk), .reset_i(rst),
    .data_o(data_o), .addr_o(addr_o), .v_o(v_o), .w_o(w_o), .wmask_o(wmask_o),
    .ready_and_i(ready_and_i),
    .data_i(data_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready)
  );

  // Transaction-level model: buffered AXI beats and outstanding request kinds.
  logic [31:0] awq[$];
  logic [35:0] wq[$];
  logic [31:0] arq[$];
  bit          tagq[$];
  bit          held, held_w;
  bit          e_v, e_w, e_rdy, e_bv, e_rv, e_awr, e_wr, e_arr;
  logic [31:0] e_addr, e_data;
  logic [3:0]  e_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, derive expectations, compare.
  task automatic settle();
    bit cw, cr;
    #1;
    cw     = (awq.size() > 0) && (wq.size() > 0);
    cr     = (arq.size() > 0);
    e_w    = held ? held_w : cw;
    e_v    = !rst && (cw || cr) && (tagq.size() < DEPTH);
    e_addr = e_w ? (awq.size() > 0 ? awq[0] : 32'h0) : (arq.size() > 0 ? arq[0] : 32'h0);
    e_data = (e_w && wq.size() > 0) ? wq[0][31:0]  : 32'h0;
    e_mask = (e_w && wq.size() > 0) ? wq[0][35:32] : 4'h0;
    e_awr  = awq.size() < DEPTH;
    e_wr   = wq.size()  < DEPTH;
    e_arr  = arq.size() < DEPTH;
    e_rdy  = !rst && tagq.size() > 0 && (tagq[0] ? bready : rready);
    e_bv   = !rst && v_i && tagq.size() > 0 && tagq[0];
    e_rv   = !rst && v_i && tagq.size() > 0 && !tagq[0];
    chk("v_o", v_o, e_v);
    if (e_v) begin
      chk("w_o", w_o, e_w);
      chk("addr_o", addr_o, e_addr);
      chk("data_o", data_o, e_data);
      chk("wmask_o", wmask_o, e_mask);
    end
    if (!rst) begin
      chk("awready", awready, e_awr);
      chk("wready", wready, e_wr);
      chk("arready", arready, e_arr);
    end
    chk("ready_and_o", ready_and_o, e_rdy);
    chk("bvalid", bvalid, e_bv);
    chk("rvalid", rvalid, e_rv);
    chk("bresp", bresp, 2'b00);
    chk("rresp", rresp, 2'b00);
    if (e_rv) chk("rdata", rdata, data_i);
  endtask

  // Clock edge: apply every handshake of this cycle to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      awq.delete(); wq.delete(); arq.delete(); tagq.delete();
      held = 0; held_w = 0;
    end else begin
      if (v_i && e_rdy) void'(tagq.pop_front());
      if (e_v && ready_and_i) begin
        if (e_w) begin void'(awq.pop_front()); void'(wq.pop_front()); end
        else     void'(arq.pop_front());
        tagq.push_back(e_w);
      end
      if (awvalid && e_awr) awq.push_back(awaddr);
      if (wvalid && e_wr)   wq.push_back({wstrb, wdata});
      if (arvalid && e_arr) arq.push_back(araddr);
      held   = e_v && !ready_and_i;
      held_w = e_w;
    end
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; arvalid = 0; v_i = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; data_i = 0;
    ready_and_i = 1; bready = 1; rready = 1;
    held = 0; held_w = 0;
    @(posedge clk); #1;

    // Reset state
    settle();
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_ready_and_o", ready_and_o, 1'b0);
    tick();
    rst = 0;
    settle();
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_v_o", v_o, 1'b0);
    tick();

    // Single write, response held off by bready=0 first
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    settle(); tick();
    idle_inputs();
    settle();
    chk("wr_v_o", v_o, 1'b1);
    chk("wr_w_o", w_o, 1'b1);
    chk("wr_addr", addr_o, 32'h10);
    chk("wr_data", data_o, 32'hDEADBEEF);
    chk("wr_mask", wmask_o, 4'hF);
    tick();
    v_i = 1; data_i = 32'h0; bready = 0;
    settle();
    chk("bstall_ready_and_o", ready_and_o, 1'b0);
    chk("bstall_bvalid", bvalid, 1'b1);
    tick();
    settle(); tick();
    bready = 1;
    settle();
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_rvalid", rvalid, 1'b0);
    chk("wr_ready_and_o", ready_and_o, 1'b1);
    tick();
    v_i = 0;

    // Single read
    arvalid = 1; araddr = 32'h20;
    settle(); tick();
    idle_inputs();
    settle();
    chk("rd_v_o", v_o, 1'b1);
    chk("rd_w_o", w_o, 1'b0);
    chk("rd_addr", addr_o, 32'h20);
    chk("rd_mask", wmask_o, 4'h0);
    tick();
    v_i = 1; data_i = 32'h1234;
    settle();
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, 32'h1234);
    tick();
    v_i = 0;

    // AW three cycles ahead of W
    awvalid = 1; awaddr = 32'h30;
    settle(); tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("aw_only_v_o", v_o, 1'b0);
      tick();
    end
    wvalid = 1; wdata = 32'h5555AAAA; wstrb = 4'h3;
    settle(); tick();
    idle_inputs();
    settle();
    chk("aw_late_v_o", v_o, 1'b1);
    chk("aw_late_addr", addr_o, 32'h30);
    tick();
    settle();
    chk("aw_late_once", v_o, 1'b0);
    tick();
    v_i = 1; settle(); tick(); v_i = 0;

    // Write and read pending together: write first
    ready_and_i = 0;
    awvalid = 1; awaddr = 32'h44; wvalid = 1; wdata = 32'h1; wstrb = 4'h1;
    arvalid = 1; araddr = 32'h40;
    settle(); tick();
    idle_inputs(); ready_and_i = 1;
    settle();
    chk("prio_first_w", w_o, 1'b1);
    tick();
    settle();
    chk("prio_second_w", w_o, 1'b0);
    chk("prio_second_addr", addr_o, 32'h40);
    tick();
    v_i = 1; data_i = 32'hA;
    settle();
    chk("prio_bvalid", bvalid, 1'b1);
    tick();
    data_i = 32'hB;
    settle();
    chk("prio_rvalid", rvalid, 1'b1);
    chk("prio_rdata", rdata, 32'hB);
    tick();
    v_i = 0;

    // Backpressure on a read while a write shows up behind it
    arvalid = 1; araddr = 32'h50; ready_and_i = 0;
    settle(); tick();
    idle_inputs();
    awvalid = 1; awaddr = 32'h58; wvalid = 1; wdata = 32'h77; wstrb = 4'h8;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_v_o", v_o, 1'b1);
      chk("bp_addr", addr_o, 32'h50);
      tick();
      idle_inputs();
    end
    ready_and_i = 1;
    for (int i = 0; i < 6; i++) begin
      v_i = (tagq.size() > 0); data_i = 32'h600 + 32'(i);
      settle(); tick();
    end
    v_i = 0;

    // Fill with no responses: tag queue then AW/W FIFOs saturate
    for (int i = 0; i < 5; i++) begin
      awvalid = 1; awaddr = 32'h100 + 32'(i); wvalid = 1; wdata = 32'h200 + 32'(i); wstrb = 4'h5;
      settle(); tick();
    end
    settle();
    chk("fill_v_o", v_o, 1'b0);
    chk("fill_awready", awready, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      v_i = (tagq.size() > 0); data_i = 32'h0;
      settle(); tick();
    end
    v_i = 0;

    // Reset mid-stream
    ready_and_i = 0;
    awvalid = 1; awaddr = 32'h300; wvalid = 1; arvalid = 1; araddr = 32'h304;
    settle(); tick();
    idle_inputs();
    rst = 1;
    settle();
    chk("mid_rst_v_o", v_o, 1'b0);
    tick();
    rst = 0;
    settle();
    chk("mid_rst_v_o_after", v_o, 1'b0);
    chk("mid_rst_arready", arready, 1'b1);
    tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst         = (i == 250);
      awvalid     = 1'($urandom_range(0, 1)); awaddr = $urandom;
      wvalid      = 1'($urandom_range(0, 1)); wdata  = $urandom; wstrb = 4'($urandom);
      arvalid     = 1'($urandom_range(0, 1)); araddr = $urandom;
      ready_and_i = ($urandom_range(0, 3) != 0);
      bready      = 1'($urandom_range(0, 1));
      rready      = 1'($urandom_range(0, 1));
      v_i         = !rst && (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
      data_i      = $urandom;
      settle(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
